// File: rtl/dram_sequencer.sv
// RAS/CAS sequencer with CAS-before-RAS refresh scheduling for a 68040 DRAM controller.
// Refresh is granted only from IDLE, so it never interrupts an access.
module dram_sequencer #(
  parameter int REFRESH_DIV = 390,
  parameter int RCD_CYC     = 2,
  parameter int CAS_CYC     = 2,
  parameter int RP_CYC      = 3,
  parameter int REF_CYC     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic       REQ_RW,
  input  logic [1:0] REQ_BANK,
  input  logic [3:0] REQ_BE,
  input  logic       REQ_BURST,
  output logic       GNT,
  output logic       ACK,
  output logic [1:0] BEAT,
  output logic [3:0] nRAS,
  output logic [3:0] nCAS,
  output logic       MUXSEL,
  output logic       DRAMRW,
  output logic       REF_OVF
);

  typedef enum logic [2:0] {IDLE, ROW, COL, CPRE, PRECH, REF_CAS, REF_RAS} state_t;

  state_t      state;
  logic [15:0] ref_cnt;
  logic [15:0] cyc;
  logic [2:0]  pending;
  logic        rw_q;
  logic        burst_q;
  logic [3:0]  be_q;

  logic       tick;
  logic       ref_dec;
  logic       last_beat;
  logic [3:0] col_cas;

  assign tick      = (ref_cnt == 16'd0);
  assign ref_dec   = (state == IDLE) && (pending != 3'd0);
  assign last_beat = !burst_q || (BEAT == 2'd3);
  assign col_cas   = rw_q ? 4'h0 : ~be_q;

  // A tick that lands on the same edge as a refresh grant cancels out, so it is not counted as lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ref_cnt <= 16'(REFRESH_DIV - 1);
      pending <= 3'd0;
      REF_OVF <= 1'b0;
    end else begin
      ref_cnt <= tick ? 16'(REFRESH_DIV - 1) : ref_cnt - 16'd1;
      if (tick && !ref_dec) begin
        if (pending == 3'd7) REF_OVF <= 1'b1;
        else                 pending <= pending + 3'd1;
      end else if (!tick && ref_dec) begin
        pending <= pending - 3'd1;
      end
    end
  end

  // Outputs are loaded on the edge that enters a state, so they hold for that state's whole duration.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cyc     <= 16'd0;
      rw_q    <= 1'b1;
      burst_q <= 1'b0;
      be_q    <= 4'h0;
      GNT     <= 1'b0;
      ACK     <= 1'b0;
      BEAT    <= 2'd0;
      nRAS    <= 4'hF;
      nCAS    <= 4'hF;
      MUXSEL  <= 1'b0;
      DRAMRW  <= 1'b1;
    end else begin
      GNT <= 1'b0;
      ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != 3'd0) begin
            state  <= REF_CAS;
            nCAS   <= 4'h0;
            nRAS   <= 4'hF;
            DRAMRW <= 1'b1;
            MUXSEL <= 1'b0;
          end else if (REQ) begin
            state   <= ROW;
            rw_q    <= REQ_RW;
            be_q    <= REQ_BE;
            burst_q <= REQ_BURST;
            GNT     <= 1'b1;
            BEAT    <= 2'd0;
            nRAS    <= ~(4'b0001 << REQ_BANK);
            MUXSEL  <= 1'b0;
            DRAMRW  <= REQ_RW;
            cyc     <= 16'(RCD_CYC - 1);
          end
        end
        ROW: begin
          if (cyc == 16'd0) begin
            state  <= COL;
            MUXSEL <= 1'b1;
            nCAS   <= col_cas;
            ACK    <= (CAS_CYC == 1);
            cyc    <= 16'(CAS_CYC - 1);
          end else begin
            cyc <= cyc - 16'd1;
          end
        end
        COL: begin
          if (cyc != 16'd0) begin
            cyc <= cyc - 16'd1;
            ACK <= (cyc == 16'd1);
          end else if (last_beat) begin
            state  <= PRECH;
            nRAS   <= 4'hF;
            nCAS   <= 4'hF;
            MUXSEL <= 1'b0;
            DRAMRW <= 1'b1;
            BEAT   <= 2'd0;
            cyc    <= 16'(RP_CYC - 1);
          end else begin
            state <= CPRE;
            nCAS  <= 4'hF;
            BEAT  <= BEAT + 2'd1;
          end
        end
        CPRE: begin
          state <= COL;
          nCAS  <= col_cas;
          ACK   <= (CAS_CYC == 1);
          cyc   <= 16'(CAS_CYC - 1);
        end
        PRECH: begin
          if (cyc == 16'd0) state <= IDLE;
          else              cyc   <= cyc - 16'd1;
        end
        REF_CAS: begin
          state <= REF_RAS;
          nRAS  <= 4'h0;
          cyc   <= 16'(REF_CYC - 1);
        end
        REF_RAS: begin
          if (cyc == 16'd0) begin
            state <= PRECH;
            nRAS  <= 4'hF;
            nCAS  <= 4'hF;
            cyc   <= 16'(RP_CYC - 1);
          end else begin
            cyc <= cyc - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
// Directed bench for dram_sequencer: access timing, refresh scheduling, overflow and reset abort.
// A second instance with a short refresh period exercises pending saturation.
module tb_dram_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, REQ, REQ_RW, REQ_BURST;
  logic [1:0] REQ_BANK;
  logic [3:0] REQ_BE;
  logic       GNT, ACK, MUXSEL, DRAMRW, REF_OVF;
  logic [1:0] BEAT;
  logic [3:0] nRAS, nCAS;

  logic       RESET2, REQ2;
  logic       GNT2, ACK2, MUXSEL2, DRAMRW2, REF_OVF2;
  logic [1:0] BEAT2;
  logic [3:0] nRAS2, nCAS2;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  dram_sequencer dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_BANK(REQ_BANK),
    .REQ_BE(REQ_BE), .REQ_BURST(REQ_BURST), .GNT(GNT), .ACK(ACK), .BEAT(BEAT),
    .nRAS(nRAS), .nCAS(nCAS), .MUXSEL(MUXSEL), .DRAMRW(DRAMRW), .REF_OVF(REF_OVF)
  );

  dram_sequencer #(.REFRESH_DIV(2)) dut_fast (
    .CLK(CLK), .RESET(RESET2), .REQ(REQ2), .REQ_RW(1'b1), .REQ_BANK(2'd3),
    .REQ_BE(4'hF), .REQ_BURST(1'b1), .GNT(GNT2), .ACK(ACK2), .BEAT(BEAT2),
    .nRAS(nRAS2), .nCAS(nCAS2), .MUXSEL(MUXSEL2), .DRAMRW(DRAMRW2), .REF_OVF(REF_OVF2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 ns after the last reset edge; the next edge is the first live one.
  task automatic do_reset();
    RESET = 1'b1;
    REQ = 1'b0; REQ_RW = 1'b1; REQ_BANK = 2'd0; REQ_BE = 4'h0; REQ_BURST = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (nRAS !== 4'hF) $display("[TB] FAIL reset_nras got %h want F", nRAS); else passed++;
    checks++; if (nCAS !== 4'hF) $display("[TB] FAIL reset_ncas got %h want F", nCAS); else passed++;
    checks++; if (MUXSEL !== 1'b0) $display("[TB] FAIL reset_muxsel got %b want 0", MUXSEL); else passed++;
    checks++; if (DRAMRW !== 1'b1) $display("[TB] FAIL reset_dramrw got %b want 1", DRAMRW); else passed++;
    checks++; if (GNT !== 1'b0 || ACK !== 1'b0) $display("[TB] FAIL reset_gnt_ack got %b%b want 00", GNT, ACK); else passed++;
    checks++; if (BEAT !== 2'd0 || REF_OVF !== 1'b0) $display("[TB] FAIL reset_beat_ovf got %0d %b want 0 0", BEAT, REF_OVF); else passed++;
  endtask

  task automatic test_refresh();
    logic [3:0] ras_h [1:420];
    int first = -1;
    int strays = 0;
    do_reset();
    for (int k = 1; k <= 420; k++) begin
      step();
      ras_h[k] = nRAS;
      if (GNT !== 1'b0 || ACK !== 1'b0) strays++;
      if (first < 0 && nCAS === 4'h0) first = k;
    end
    checks++; if (first != 391) $display("[TB] FAIL refresh_start got cycle %0d want 391", first); else passed++;
    checks++; if (strays != 0) $display("[TB] FAIL refresh_no_gnt_ack got %0d pulses want 0", strays); else passed++;
    if (first >= 1 && first <= 410) begin
      checks++; if (ras_h[first] !== 4'hF) $display("[TB] FAIL refresh_cas_first got nRAS %h want F", ras_h[first]); else passed++;
      for (int k = 1; k <= 4; k++) begin
        checks++; if (ras_h[first+k] !== 4'h0) $display("[TB] FAIL refresh_ras_low[%0d] got %h want 0", k, ras_h[first+k]); else passed++;
      end
      checks++; if (ras_h[first+5] !== 4'hF) $display("[TB] FAIL refresh_ras_release got %h want F", ras_h[first+5]); else passed++;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    REQ = 1'b1; REQ_RW = 1'b1; REQ_BANK = 2'd2; REQ_BE = 4'h5; REQ_BURST = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) REQ = 1'b0;
      checks++; if (GNT !== (c == 1)) $display("[TB] FAIL read_gnt c%0d got %b want %b", c, GNT, c == 1); else passed++;
      checks++; if (nRAS !== ((c <= 4) ? 4'b1011 : 4'hF)) $display("[TB] FAIL read_nras c%0d got %b", c, nRAS); else passed++;
      checks++; if (nCAS !== ((c == 3 || c == 4) ? 4'h0 : 4'hF)) $display("[TB] FAIL read_ncas c%0d got %b", c, nCAS); else passed++;
      checks++; if (MUXSEL !== (c == 3 || c == 4)) $display("[TB] FAIL read_muxsel c%0d got %b", c, MUXSEL); else passed++;
      checks++; if (ACK !== (c == 4)) $display("[TB] FAIL read_ack c%0d got %b want %b", c, ACK, c == 4); else passed++;
      checks++; if (DRAMRW !== 1'b1) $display("[TB] FAIL read_dramrw c%0d got %b want 1", c, DRAMRW); else passed++;
    end
  endtask

  task automatic test_write_burst();
    bit col, ackc;
    do_reset();
    REQ = 1'b1; REQ_RW = 1'b0; REQ_BANK = 2'd0; REQ_BE = 4'b0011; REQ_BURST = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 1) REQ = 1'b0;
      col  = (c >= 3 && c <= 13) && ((c % 3) != 2);
      ackc = (c == 4 || c == 7 || c == 10 || c == 13);
      checks++; if (nCAS !== (col ? 4'b1100 : 4'hF)) $display("[TB] FAIL burst_ncas c%0d got %b", c, nCAS); else passed++;
      checks++; if (ACK !== ackc) $display("[TB] FAIL burst_ack c%0d got %b want %b", c, ACK, ackc); else passed++;
      checks++; if (DRAMRW !== (c > 13)) $display("[TB] FAIL burst_dramrw c%0d got %b want %b", c, DRAMRW, c > 13); else passed++;
      checks++; if (nRAS !== ((c <= 13) ? 4'b1110 : 4'hF)) $display("[TB] FAIL burst_nras c%0d got %b", c, nRAS); else passed++;
      if (ackc) begin
        checks++; if (BEAT !== 2'((c - 4) / 3)) $display("[TB] FAIL burst_beat c%0d got %0d want %0d", c, BEAT, (c - 4) / 3); else passed++;
      end
      if (col || c <= 2 || c >= 14) begin
        checks++; if (MUXSEL !== col) $display("[TB] FAIL burst_muxsel c%0d got %b want %b", c, MUXSEL, col); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit want;
    do_reset();
    REQ = 1'b1; REQ_RW = 1'b0; REQ_BANK = 2'd1; REQ_BE = 4'hF; REQ_BURST = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      want = (c == 1 || c == 9 || c == 17);
      checks++; if (GNT !== want) $display("[TB] FAIL b2b_gnt c%0d got %b want %b", c, GNT, want); else passed++;
    end
    REQ = 1'b0;
  endtask

  task automatic test_refresh_priority();
    int gnt_at = -1;
    do_reset();
    for (int k = 1; k <= 390; k++) step();
    REQ = 1'b1; REQ_RW = 1'b1; REQ_BANK = 2'd3; REQ_BE = 4'hF; REQ_BURST = 1'b0;
    for (int k = 391; k <= 420; k++) begin
      step();
      if (k == 391) begin
        checks++; if (nCAS !== 4'h0 || GNT !== 1'b0) $display("[TB] FAIL prio_refresh_first got nCAS %h GNT %b want 0 0", nCAS, GNT); else passed++;
      end
      if (gnt_at < 0 && GNT === 1'b1) begin
        gnt_at = k;
        REQ = 1'b0;
      end
    end
    checks++; if (gnt_at != 400) $display("[TB] FAIL prio_gnt_cycle got %0d want 400", gnt_at); else passed++;
  endtask

  task automatic test_overflow();
    RESET2 = 1'b1; REQ2 = 1'b0;
    step();
    step();
    RESET2 = 1'b0; REQ2 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++; if (REF_OVF2 !== 1'b0) $display("[TB] FAIL ovf_early got %b want 0", REF_OVF2); else passed++;
    for (int k = 0; k < 60; k++) step();
    checks++; if (REF_OVF2 !== 1'b1) $display("[TB] FAIL ovf_set got %b want 1", REF_OVF2); else passed++;
    for (int k = 0; k < 100; k++) step();
    checks++; if (REF_OVF2 !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", REF_OVF2); else passed++;
    RESET2 = 1'b1;
    step();
    checks++; if (REF_OVF2 !== 1'b0) $display("[TB] FAIL ovf_cleared got %b want 0", REF_OVF2); else passed++;
    RESET2 = 1'b0; REQ2 = 1'b0;
  endtask

  task automatic test_reset_in_burst();
    int acks = 0;
    do_reset();
    REQ = 1'b1; REQ_RW = 1'b1; REQ_BANK = 2'd1; REQ_BE = 4'hF; REQ_BURST = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) REQ = 1'b0;
    end
    checks++; if (BEAT !== 2'd1 || nCAS !== 4'h0) $display("[TB] FAIL abort_setup got BEAT %0d nCAS %h want 1 0", BEAT, nCAS); else passed++;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++; if (nRAS !== 4'hF || nCAS !== 4'hF) $display("[TB] FAIL abort_strobes got %h %h want F F", nRAS, nCAS); else passed++;
    checks++; if (ACK !== 1'b0 || BEAT !== 2'd0) $display("[TB] FAIL abort_ack_beat got %b %0d want 0 0", ACK, BEAT); else passed++;
    checks++; if (MUXSEL !== 1'b0 || DRAMRW !== 1'b1) $display("[TB] FAIL abort_mux_rw got %b %b want 0 1", MUXSEL, DRAMRW); else passed++;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ACK === 1'b1 || nCAS !== 4'hF) acks++;
    end
    checks++; if (acks != 0) $display("[TB] FAIL abort_quiet got %0d active cycles want 0", acks); else passed++;
  endtask

  initial begin
    RESET2 = 1'b1; REQ2 = 1'b0;
    test_reset();
    test_refresh();
    test_single_read();
    test_write_burst();
    test_back_to_back();
    test_refresh_priority();
    test_overflow();
    test_reset_in_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
